ring_bridge_arbiter: RTL and testbench

- Shares one inter-ring bridge FIFO between the two connect routers that sit at a local-ring/global-ring junction.
- Each connect router pushes productive flits, and the arbiter tells each one when it must hold off (bfull).
- Admitted flits are buffered in order and presented to the next ring router's injection port, which drains them with an accept handshake.
- Round-robin arbitration guarantees no FIFO overflow and no starvation when only one slot remains.

---
 rtl/ring_bridge_arbiter.sv | 116 +++++++++++
 tb/tb_ring_bridge_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ring_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ring_bridge_arbiter
// Purpose  : Round-robin shared bridge FIFO between two connect routers
//            feeding one ring injection port.
// Revision : 1.0
// ============================================================================
module ring_bridge_arbiter #(
  parameter int FLIT_W    = 16,  // matches the control word width
  parameter int VALID_BIT = 15,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push0,
  input  logic [FLIT_W-1:0] flit0,
  input  logic              push1,
  input  logic [FLIT_W-1:0] flit1,
  output logic              bfull0,
  output logic              bfull1,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              out_accept,
  output logic              proto_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = PTR_W + 1;

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rr;
  logic              r_proto_err;

  logic [CNT_W-1:0]  w_free;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_pop;
  logic              w_fav_acc;
  logic [1:0]        w_n_push;
  logic [FLIT_W-1:0] w_first_flit;
  logic [FLIT_W-1:0] w_second_flit;

  // Pointer advance that wraps modulo DEPTH, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [1:0] n);
    logic [SUM_W-1:0] s;
    s = {1'b0, p} + SUM_W'(n);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign w_free = CNT_W'(DEPTH) - r_count;

  // Back-pressure depends on registered state only; the last slot goes to rr.
  always_comb begin
    bfull0 = 1'b0;
    bfull1 = 1'b0;
    if (w_free == '0) begin
      bfull0 = 1'b1;
      bfull1 = 1'b1;
    end else if (w_free == CNT_W'(1)) begin
      bfull0 = r_rr;
      bfull1 = ~r_rr;
    end
  end

  assign w_acc0    = push0 & ~bfull0;
  assign w_acc1    = push1 & ~bfull1;
  assign w_pop     = out_accept & (r_count != '0);
  assign w_fav_acc = r_rr ? w_acc1 : w_acc0;
  assign w_n_push  = {1'b0, w_acc0} + {1'b0, w_acc1};

  always_comb begin
    w_first_flit  = flit0;
    w_second_flit = flit1;
    if (w_acc0 && w_acc1) begin
      w_first_flit  = r_rr ? flit1 : flit0;
      w_second_flit = r_rr ? flit0 : flit1;
    end else if (w_acc1) begin
      w_first_flit  = flit1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_n_push != 2'd0) r_mem[r_wr_ptr] <= w_first_flit;
    if (w_n_push == 2'd2) r_mem[ptr_add(r_wr_ptr, 2'd1)] <= w_second_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_rr        <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_wr_ptr <= ptr_add(r_wr_ptr, w_n_push);
      if (w_pop) r_rd_ptr <= ptr_add(r_rd_ptr, 2'd1);
      r_count  <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
      if (w_fav_acc) r_rr <= ~r_rr;
      if ((push0 && bfull0) || (push1 && bfull1)) r_proto_err <= 1'b1;
    end
  end

  always_comb begin
    out_flit = '0;
    if (r_count != '0) out_flit = r_mem[r_rd_ptr] | (FLIT_W'(1) << VALID_BIT);
  end

  assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_bridge_arbiter
// Purpose  : Directed self-checking bench for ring_bridge_arbiter.
// Revision : 1.0
// ============================================================================
module tb_ring_bridge_arbiter;

  localparam int FLIT_W = 16;
  localparam logic [15:0] V = 16'h8000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push0 = 1'b0;
  logic [FLIT_W-1:0] flit0 = '0;
  logic              push1 = 1'b0;
  logic [FLIT_W-1:0] flit1 = '0;
  logic              bfull0;
  logic              bfull1;
  logic [FLIT_W-1:0] out_flit;
  logic              out_accept = 1'b0;
  logic              proto_err;

  int total = 0;
  int bad   = 0;
  logic [15:0] q[$];

  ring_bridge_arbiter #(.FLIT_W(16), .VALID_BIT(15), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .push0(push0), .flit0(flit0), .push1(push1), .flit1(flit1),
    .bfull0(bfull0), .bfull1(bfull1),
    .out_flit(out_flit), .out_accept(out_accept), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset and idle
    tick(); tick();
    chk("rst_bfull0", 32'(bfull0), 0);
    chk("rst_bfull1", 32'(bfull1), 0);
    chk("rst_out", 32'(out_flit), 0);
    chk("rst_perr", 32'(proto_err), 0);
    rst_n = 1'b1;
    tick();

    // three single pushes: A1 (rr 0->1), B2 (rr 1->0), C3 (rr 0->1)
    push0 = 1; flit0 = 16'h00A1; tick();
    push0 = 0; push1 = 1; flit1 = 16'h00B2; tick();
    push1 = 0; push0 = 1; flit0 = 16'h00C3; tick();
    push0 = 0;
    chk("cnt3_bfull0", 32'(bfull0), 1);
    chk("cnt3_bfull1", 32'(bfull1), 0);
    out_accept = 1;
    chk("drain_a1", 32'(out_flit), 32'(V | 16'h00A1)); tick();
    chk("drain_b2", 32'(out_flit), 32'(V | 16'h00B2)); tick();
    chk("drain_c3", 32'(out_flit), 32'(V | 16'h00C3)); tick();
    chk("drain_empty", 32'(out_flit), 0);
    out_accept = 0;
    tick();  // extra accept-free cycle; empty accept ignored above

    // refill to three then reset asynchronously mid-burst (rr ends at 1)
    push0 = 1; flit0 = 16'h00D4; tick();
    push0 = 0; push1 = 1; flit1 = 16'h00E5; tick();
    push1 = 0; push0 = 1; flit0 = 16'h00F6; tick();
    push0 = 0;
    chk("pre_rst_head", 32'(out_flit), 32'(V | 16'h00D4));
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(out_flit), 0);
    chk("midrst_bfull0", 32'(bfull0), 0);
    chk("midrst_bfull1", 32'(bfull1), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // both push two cycles, rr=0: 11,22 then (rr=1) 44,33
    push0 = 1; push1 = 1; flit0 = 16'h0011; flit1 = 16'h0022; tick();
    flit0 = 16'h0033; flit1 = 16'h0044; tick();
    push0 = 0; push1 = 0;
    chk("full_bfull0", 32'(bfull0), 1);
    chk("full_bfull1", 32'(bfull1), 1);
    chk("full_head", 32'(out_flit), 32'(V | 16'h0011));
    chk("full_perr", 32'(proto_err), 0);
    q = '{16'h0022, 16'h0044, 16'h0033};

    // drain one: free=1, rr=0 favours port 0
    out_accept = 1; tick(); out_accept = 0;
    chk("free1_bfull0", 32'(bfull0), 0);
    chk("free1_bfull1", 32'(bfull1), 1);

    // free==1 contention with one drain per cycle: grants alternate 0,1,0,1
    out_accept = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("alt%0d_bfull0", i), 32'(bfull0), 32'(i % 2));
      chk($sformatf("alt%0d_bfull1", i), 32'(bfull1), 32'(1 - i % 2));
      chk($sformatf("alt%0d_head", i), 32'(out_flit), 32'(V | q[0]));
      push0 = ~bfull0; push1 = ~bfull1;
      flit0 = 16'h00A0 + 16'(i); flit1 = 16'h00B0 + 16'(i);
      void'(q.pop_front());
      q.push_back((i % 2 == 0) ? 16'h00A0 + 16'(i) : 16'h00B0 + 16'(i));
      tick();
    end
    push0 = 0; push1 = 0; out_accept = 0;

    // fill the last slot from port 0 (rr=0 -> 1)
    push0 = 1; flit0 = 16'h0077; tick(); push0 = 0;
    q.push_back(16'h0077);
    chk("refull_bfull0", 32'(bfull0), 1);
    chk("refull_bfull1", 32'(bfull1), 1);

    // full plus pop: no write that cycle, port 1 (favoured) gets the slot next
    out_accept = 1; tick(); out_accept = 0;
    void'(q.pop_front());
    chk("pop_full_bfull0", 32'(bfull0), 1);
    chk("pop_full_bfull1", 32'(bfull1), 0);
    push1 = 1; flit1 = 16'h0088; tick(); push1 = 0;
    q.push_back(16'h0088);
    chk("slot_bfull0", 32'(bfull0), 1);
    chk("slot_bfull1", 32'(bfull1), 1);
    chk("honour_perr", 32'(proto_err), 0);

    // protocol violation: push1 while bfull1=1
    push1 = 1; flit1 = 16'h0099; tick(); push1 = 0;
    chk("viol_perr", 32'(proto_err), 1);
    chk("viol_bfull0", 32'(bfull0), 1);
    chk("viol_bfull1", 32'(bfull1), 1);
    out_accept = 1;
    while (q.size() > 0) begin
      chk("final_drain", 32'(out_flit), 32'(V | q[0]));
      void'(q.pop_front());
      tick();
    end
    out_accept = 0;
    chk("final_empty", 32'(out_flit), 0);
    chk("perr_sticky", 32'(proto_err), 1);
    rst_n = 1'b0;
    #1;
    chk("perr_cleared", 32'(proto_err), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
